// File: rtl/data_memory_pkg.sv
// Shared definitions for the latency-configurable data memory.
//   size encodings : SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD
//   state_t        : controller FSM states
//   lane_mask()    : byte-enable pattern for a size at a word offset
//   size_bytes()   : access width in bytes (0 for the reserved encoding)
package data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SIZE_BYTE: base = 4'b0001;
            SIZE_HALF: base = 4'b0011;
            SIZE_WORD: base = 4'b1111;
            default:   base = 4'b0000;
        endcase
        // Lanes shifted past bit 3 only occur for misaligned accesses, which never write.
        return base << offset;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised byte storage with per-lane write enables.
//   clk_i   : clock
//   en_i    : access strobe; read (and optional write) on this edge
//   we_i    : write the lanes selected by be_i
//   be_i    : byte-lane enables, bit i covers wdata_i[8i+7:8i]
//   addr_i  : word index
//   wdata_i : write data, already placed on its lanes
//   rdata_o : registered read data (old contents on a write edge)
// Contents are deliberately not reset.
module dmem_byte_array #(
    parameter  int DEPTH = 1024,
    localparam int WORDS = DEPTH / 4,
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/data_memory_lat.sv
// Byte-addressable data memory with a fixed, configurable access latency.
//   clk_i      : clock
//   rst_i      : asynchronous active-low reset
//   req_i      : request strobe, taken only while busy_o is low
//   we_i       : 1 = store, 0 = load
//   size_i     : 00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i : load extension, 1 = zero, 0 = sign
//   addr_i     : byte address
//   wdata_i    : store data, right-aligned
//   busy_o     : request in flight
//   ack_o      : one-cycle completion pulse
//   err_o      : access error, qualified by ack_o
//   rdata_o    : load result, held until the next ack
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for req_i; request fields captured on acceptance
// ST_WAIT | latency countdown; array accessed on the edge cnt_q == 0
// ST_RESP | ack_o high for one cycle, result presented
module data_memory_lat
    import data_memory_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    localparam int WORDS = DEPTH / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q, uns_q;
    logic [1:0]         size_q;
    logic [31:0]        addr_q, wdata_q;
    logic [31:0]        rdata_hold_q;
    logic               err_hold_q;

    logic               access;
    logic               misalign, range_err, err_c;
    logic [32:0]        last_addr;
    logic [31:0]        lane_wdata, arr_rdata, shifted, load_val;

    // Range check on 33 bits so addresses near 2^32 cannot wrap back into range.
    assign last_addr = {1'b0, addr_q} + {30'd0, size_bytes(size_q)} - 33'd1;
    assign range_err = last_addr >= 33'(DEPTH);
    assign misalign  = ((size_q == SIZE_HALF) && addr_q[0]) ||
                       ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
    assign err_c     = (size_q == SIZE_RSVD) || misalign || range_err;

    assign access = (state_q == ST_WAIT) && (cnt_q == '0);

    always_comb begin
        lane_wdata = wdata_q;
        case (size_q)
            SIZE_BYTE: lane_wdata = {4{wdata_q[7:0]}};
            SIZE_HALF: lane_wdata = {2{wdata_q[15:0]}};
            default:   lane_wdata = wdata_q;
        endcase
    end

    dmem_byte_array #(.DEPTH(DEPTH)) u_array (
        .clk_i   (clk_i),
        .en_i    (access),
        .we_i    (we_q && !err_c),
        .be_i    (lane_mask(size_q, addr_q[1:0])),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (lane_wdata),
        .rdata_o (arr_rdata)
    );

    assign shifted = arr_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = 32'd0;
        case (size_q)
            SIZE_BYTE: load_val = uns_q ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_val = uns_q ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: load_val = arr_rdata;
            default:   load_val = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_i) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if ((state_q == ST_IDLE) && req_i) begin
            cnt_q   <= CNT_W'(LATENCY - 1);
            we_q    <= we_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    // Outputs come from registers only: live result during RESP, held copy otherwise.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_hold_q <= 32'd0;
            err_hold_q   <= 1'b0;
        end else if (ack_o) begin
            rdata_hold_q <= rdata_o;
            err_hold_q   <= err_o;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign ack_o   = (state_q == ST_RESP);
    assign err_o   = ack_o ? err_c : err_hold_q;
    assign rdata_o = ack_o ? ((err_c || we_q) ? 32'd0 : load_val) : rdata_hold_q;

endmodule

// File: tb/tb_data_memory_lat.sv
module tb_data_memory_lat;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // LATENCY=1 instance
    logic        rst1, req1, we1, uns1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1;
    logic        busy1, ack1, err1;
    logic [31:0] rdata1;

    // LATENCY=4 instance
    logic        rst4, req4, we4, uns4;
    logic [1:0]  size4;
    logic [31:0] addr4, wdata4;
    logic        busy4, ack4, err4;
    logic [31:0] rdata4;

    data_memory_lat #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1), .size_i(size1),
        .unsigned_i(uns1), .addr_i(addr1), .wdata_i(wdata1),
        .busy_o(busy1), .ack_o(ack1), .err_o(err1), .rdata_o(rdata1)
    );

    data_memory_lat #(.DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst4), .req_i(req4), .we_i(we4), .size_i(size4),
        .unsigned_i(uns4), .addr_i(addr4), .wdata_i(wdata4),
        .busy_o(busy4), .ack_o(ack4), .err_o(err4), .rdata_o(rdata4)
    );

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic        chk_rd;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t m1, m4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitors: every ack pops one expectation, including its cycle of arrival.
    always @(negedge clk) begin
        if (ack1 === 1'b1) begin
            if (q1.size() == 0) chk("ack1_unexpected", 32'd1, 32'd0);
            else begin
                m1 = q1.pop_front();
                chk("ack1_cycle", 32'(cyc), 32'(m1.cyc));
                chk("err1", 32'(err1), 32'(m1.err));
                if (m1.chk_rd) chk("rdata1", rdata1, m1.rd);
            end
        end
    end

    always @(negedge clk) begin
        if (ack4 === 1'b1) begin
            if (q4.size() == 0) chk("ack4_unexpected", 32'd1, 32'd0);
            else begin
                m4 = q4.pop_front();
                chk("ack4_cycle", 32'(cyc), 32'(m4.cyc));
                chk("err4", 32'(err4), 32'(m4.err));
                if (m4.chk_rd) chk("rdata4", rdata4, m4.rd);
            end
        end
    end

    task automatic wait_idle(input bit s4);
        int n = 0;
        while ((s4 ? busy4 : busy1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(s4 ? "idle4" : "idle1", 32'(s4 ? busy4 : busy1), 32'd0);
    endtask

    task automatic issue(input bit s4, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic xerr, input logic chkrd, input logic [31:0] xrd);
        exp_t e;
        @(negedge clk);
        wait_idle(s4);
        if (s4) begin we4 = we; size4 = sz; uns4 = uns; addr4 = a; wdata4 = wd; req4 = 1'b1; end
        else    begin we1 = we; size1 = sz; uns1 = uns; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        @(posedge clk);
        #1;
        e.err = xerr; e.rd = xrd; e.chk_rd = chkrd; e.cyc = cyc + (s4 ? 4 : 1);
        if (s4) q4.push_back(e);
        else    q1.push_back(e);
        @(negedge clk);
        // Scramble inputs after acceptance; the captured request must not notice.
        if (s4) begin req4 = 1'b0; we4 = ~we; size4 = sz ^ 2'b11; uns4 = ~uns; addr4 = ~a; wdata4 = ~wd; end
        else    begin req1 = 1'b0; we1 = ~we; size1 = sz ^ 2'b11; uns1 = ~uns; addr1 = ~a; wdata1 = ~wd; end
        wait_idle(s4);
    endtask

    int acc [3];
    int nb, n;

    initial begin
        rst1 = 1'b0; req1 = 1'b0; we1 = 1'b0; uns1 = 1'b0; size1 = 2'b00; addr1 = '0; wdata1 = '0;
        rst4 = 1'b0; req4 = 1'b0; we4 = 1'b0; uns4 = 1'b0; size4 = 2'b00; addr4 = '0; wdata4 = '0;
        repeat (2) @(negedge clk);
        rst1 = 1'b1; rst4 = 1'b1;
        @(negedge clk);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_rdata4", rdata4, 32'd0);

        // LATENCY=1 functional vectors: we, size, uns, addr, wdata, err, chk_rd, rdata
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("hold_rdata1", rdata1, 32'hDEADBEEF);
        chk("hold_err1", 32'(err1), 32'd0);
        issue(0, 1, 2'b00, 0, 32'h11, 32'h00000080, 0, 0, 32'h0);
        issue(0, 0, 2'b00, 0, 32'h11, 32'h0,        0, 1, 32'hFFFFFF80);
        issue(0, 0, 2'b00, 1, 32'h11, 32'h0,        0, 1, 32'h00000080);
        issue(0, 0, 2'b10, 1, 32'h10, 32'h0,        0, 1, 32'hDEAD80EF);
        issue(0, 0, 2'b10, 0, 32'h12, 32'h0,        1, 1, 32'h0);
        repeat (2) @(negedge clk);
        chk("hold_err_set1", 32'(err1), 32'd1);
        chk("hold_rdata_zero1", rdata1, 32'd0);
        issue(0, 0, 2'b01, 0, 32'h13, 32'h0,        1, 1, 32'h0);
        issue(0, 0, 2'b11, 0, 32'h10, 32'h0,        1, 1, 32'h0);
        issue(0, 0, 2'b10, 0, DEPTH - 2, 32'h0,     1, 1, 32'h0);
        issue(0, 1, 2'b10, 0, 32'h12, 32'h11111111, 1, 0, 32'h0);
        issue(0, 1, 2'b11, 0, 32'h10, 32'h22222222, 1, 0, 32'h0);
        issue(0, 1, 2'b00, 0, DEPTH,  32'h00000077, 1, 0, 32'h0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0,        0, 1, 32'hDEAD80EF);
        issue(0, 1, 2'b10, 0, DEPTH - 4, 32'hA5A5A5A5, 0, 0, 32'h0);
        issue(0, 0, 2'b10, 0, DEPTH - 4, 32'h0,     0, 1, 32'hA5A5A5A5);
        issue(0, 0, 2'b00, 1, DEPTH - 1, 32'h0,     0, 1, 32'h000000A5);
        issue(0, 0, 2'b01, 0, DEPTH - 2, 32'h0,     0, 1, 32'hFFFFA5A5);
        issue(0, 0, 2'b01, 0, DEPTH - 1, 32'h0,     1, 1, 32'h0);
        issue(0, 1, 2'b01, 0, 32'h14, 32'hBEEFA5C3, 0, 0, 32'h0);
        issue(0, 0, 2'b01, 0, 32'h14, 32'h0,        0, 1, 32'hFFFFA5C3);
        issue(0, 0, 2'b01, 1, 32'h14, 32'h0,        0, 1, 32'h0000A5C3);
        issue(0, 0, 2'b00, 1, 32'h15, 32'h0,        0, 1, 32'h000000A5);
        issue(0, 0, 2'b00, 0, 32'h14, 32'h0,        0, 1, 32'hFFFFFFC3);
        issue(0, 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,  1, 1, 32'h0);

        // LATENCY=4: seed a word, then back-to-back requests with req held high
        issue(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h20, 32'h0,        0, 1, 32'hCAFEF00D);
        @(negedge clk);
        wait_idle(1);
        we4 = 1'b0; size4 = 2'b10; uns4 = 1'b0; addr4 = 32'h20; wdata4 = 32'h0; req4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            @(posedge clk);
            #1;
            acc[k] = cyc;
            e.err = 1'b0; e.rd = 32'hCAFEF00D; e.chk_rd = 1'b1; e.cyc = cyc + 4;
            q4.push_back(e);
            nb = 0;
            n = 0;
            do begin
                @(negedge clk);
                if (busy4) nb++;
                n++;
            end while (busy4 && n < 20);
            chk("busy4_cycles", 32'(nb), 32'd5);
            if (k > 0) chk("accept4_spacing", 32'(acc[k] - acc[k-1]), 32'd6);
        end
        req4 = 1'b0;

        // LATENCY=4: reset before the access edge aborts a store
        @(negedge clk);
        wait_idle(1);
        we4 = 1'b1; size4 = 2'b10; addr4 = 32'h20; wdata4 = 32'h12345678; req4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        chk("abort_busy4", 32'(busy4), 32'd0);
        chk("abort_ack4", 32'(ack4), 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_idle4", 32'(busy4), 32'd0);
        chk("abort_rdata4", rdata4, 32'd0);
        chk("abort_err4", 32'(err4), 32'd0);
        issue(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 1, 32'hCAFEF00D);

        repeat (4) @(negedge clk);
        chk("q1_drain", 32'(q1.size()), 32'd0);
        chk("q4_drain", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
